// File: rtl/led_sel_scanner_pkg.sv
// Shared types and constants for the debug-select scanner and its capture bank.
package led_sel_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } scan_state_t;

  localparam int SEL_W     = 3;
  localparam int LED_W_DEF = 27;

endpackage

// File: rtl/led_sel_scanner_capture_bank.sv
// Register bank holding one captured LED value per select index, with a
// per-entry changed flag and a combinational read port.
module led_capture_bank
  import led_sel_scanner_pkg::*;
#(
  parameter int NUM_SEL = 5,
  parameter int LED_W   = LED_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [SEL_W-1:0]   i_wr_idx,
  input  logic [LED_W-1:0]   i_wr_data,
  input  logic [SEL_W-1:0]   i_rd_idx,
  output logic [LED_W-1:0]   o_rd_data,
  output logic [NUM_SEL-1:0] o_changed
);

  logic [LED_W-1:0] w_entry [NUM_SEL];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_entry
      logic [LED_W-1:0] r_value;
      logic             r_chg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_value <= '0;
          r_chg   <= 1'b0;
        end else if (i_we && (i_wr_idx == SEL_W'(gi))) begin
          r_value <= i_wr_data;
          r_chg   <= (i_wr_data != r_value);
        end
      end

      assign w_entry[gi]   = r_value;
      assign o_changed[gi] = r_chg;
    end
  endgenerate

  // Indices beyond the scanned range read back as zero.
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (i_rd_idx == SEL_W'(i)) o_rd_data = w_entry[i];
    end
  end

endmodule

// File: rtl/led_sel_scanner.sv
// Steps the system debug select through every index, lets the LED bus settle,
// and captures each value into a readable bank.
module led_sel_scanner
  import led_sel_scanner_pkg::*;
#(
  parameter int NUM_SEL  = 5,
  parameter int SETTLE   = 2,
  parameter int LED_W    = LED_W_DEF,
  parameter int IDLE_SEL = 2
) (
  input  logic               clk,
  input  logic               SYS_reset,
  input  logic               start,
  input  logic               continuous,
  output logic [SEL_W-1:0]   SYS_output_sel,
  input  logic [LED_W-1:0]   SYS_leds,
  output logic               busy,
  output logic               done,
  output logic               frame_valid,
  output logic [NUM_SEL-1:0] changed,
  input  logic [SEL_W-1:0]   rd_idx,
  output logic [LED_W-1:0]   rd_data
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEL - 1);
  localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(IDLE_SEL);

  scan_state_t      r_state, w_state_next;
  logic [SEL_W-1:0] r_sel, w_sel_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_fv, w_fv_next;
  logic             w_we;

  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fv    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_fv    <= w_fv_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_fv_next    = r_fv;
    w_we         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_WAIT;
          w_sel_next   = '0;
          w_cnt_next   = CNT_LOAD;
          w_busy_next  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_next = ST_CAPTURE;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      ST_CAPTURE: begin
        w_we = 1'b1;
        if (r_sel < SEL_LAST) begin
          w_sel_next   = r_sel + 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_state_next = ST_WAIT;
        end else begin
          w_done_next = 1'b1;
          w_fv_next   = 1'b1;
          // continuous is only looked at here, so dropping it mid-frame finishes the frame
          if (continuous) begin
            w_sel_next   = '0;
            w_cnt_next   = CNT_LOAD;
            w_state_next = ST_WAIT;
          end else begin
            w_busy_next  = 1'b0;
            w_sel_next   = SEL_IDLE;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  led_capture_bank #(
    .NUM_SEL (NUM_SEL),
    .LED_W   (LED_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (SYS_reset),
    .i_we      (w_we),
    .i_wr_idx  (r_sel),
    .i_wr_data (SYS_leds),
    .i_rd_idx  (rd_idx),
    .o_rd_data (rd_data),
    .o_changed (changed)
  );

  assign SYS_output_sel = r_sel;
  assign busy           = r_busy;
  assign done           = r_done;
  assign frame_valid    = r_fv;

endmodule

// File: doc/led_sel_scanner.md
Name: led_sel_scanner

Overview:
- Reader-side counterpart of the system debug port.
- The system exposes internal values on SYS_leds according to SYS_output_sel. This block drives SYS_output_sel through indices 0..NUM_SEL-1, waits for the LED bus to settle, and captures each value into a register bank.
- The captured frame is readable by index. A per-index change mask supports automated bring-up and on-board debug without a testbench.

Parameters:
- NUM_SEL, 5, number of select indices scanned (1..8).
- SETTLE, 2, wait cycles after changing SYS_output_sel before sampling (>=1).
- LED_W, 27, SYS_leds width.
- IDLE_SEL, 2, value driven on SYS_output_sel while not scanning.

Ports:
- clk  in  1  system clock, rising edge.
- SYS_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-shot scan request; sampled only in IDLE.
- continuous  in  1  when high at frame end, the next frame starts immediately.
- SYS_output_sel  out  3  select driven to the system debug mux.
- SYS_leds  in  LED_W  debug value returned by the system.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at end of each frame.
- frame_valid  out  1  at least one full frame captured since reset.
- changed  out  NUM_SEL  bit i set if bank[i] changed on the last capture of index i.
- rd_idx  in  3  bank read index.
- rd_data  out  LED_W  combinational bank[rd_idx]; 0 if rd_idx>=NUM_SEL.

Behaviour:
- Reset (SYS_reset=0, asynchronous) sets:
  - state=IDLE, SYS_output_sel=IDLE_SEL;
  - busy=0, done=0, frame_valid=0, changed=0;
  - all bank entries=0, settle counter=0.
- Reset mid-scan aborts the frame. Partial captures are discarded because the bank clears.
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE:
  - start=1 at an edge leads to WAIT. At the same edge: SYS_output_sel=0, cnt=SETTLE-1, busy=1.
  - Otherwise the FSM stays in IDLE.
- WAIT:
  - Decrement cnt each edge.
  - When cnt==0 at an edge, go to CAPTURE.
  - SYS_output_sel is held stable throughout.
- CAPTURE (one cycle): at the edge leaving CAPTURE:
  - bank[sel] <= SYS_leds;
  - changed[sel] <= (SYS_leds != old bank[sel]).
  - If sel < NUM_SEL-1: sel <= sel+1, cnt <= SETTLE-1, go to WAIT.
  - Otherwise:
    - done <= 1 and frame_valid <= 1.
    - If continuous=1: sel <= 0, cnt <= SETTLE-1, go to WAIT, busy stays 1.
    - Otherwise: busy <= 0, sel <= IDLE_SEL, go to IDLE.
- Timing, counting edges from the start-accept edge E0:
  - Index i is sampled at edge E0 + (i+1)*(SETTLE+1).
  - Frame length is NUM_SEL*(SETTLE+1) cycles. With defaults this is 15; the last capture is at E15.
  - done is high exactly one cycle, in the cycle following the last-capture edge.
  - In one-shot mode, busy falls on the same edge that raises done.
- Other rules:
  - start while busy is ignored (not queued).
  - start and continuous together in IDLE: start is accepted; continuous is evaluated only at frame end.
  - Dropping continuous mid-frame lets the current frame complete, then the FSM returns to IDLE.
  - First frame: changed[i] compares against the reset value 0.
  - SYS_output_sel is registered, with no glitches between indices. sel width is 3 bits; the value never exceeds NUM_SEL-1 while scanning.
  - rd_data is purely combinational and may be read at any time, including during a scan. An entry updates at its capture edge.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, CAPTURE=2'd2);
  - SEL_W=3;
  - default LED_W=27.
- One natural sub-module: led_capture_bank. It contains the NUM_SEL x LED_W register array, write enable, compare-to-old logic producing the changed bit, and the combinational read port.
- FSM, counter and select logic live in the top.

Test Plan:
- Defaults. Model SYS_leds = 27'h100 + SYS_output_sel with 1-cycle lag. Pulse start:
  - busy rises at E0; samples occur at E3, E6, E9, E12, E15;
  - rd_data for idx 0..4 = 27'h100..27'h104;
  - done pulses in the single cycle after E15;
  - frame_valid=1, changed=5'b11111, SYS_output_sel returns to 2.
- Rerun with an identical model:
  - changed=5'b00000.
  - Then alter only index 3 to 27'h7FFFFFF and rerun: changed=5'b01000, rd_idx=3 reads 27'h7FFFFFF.
- continuous=1:
  - done pulses every 15 cycles;
  - SYS_output_sel goes 4 to 0 with no IDLE cycle; busy stays 1.
  - Drop continuous at cycle 7 of frame 3: frame completes, busy=0 at its end.
- Assert SYS_reset=0 asynchronously mid-WAIT, at index 2:
  - all outputs reset immediately (without waiting for a clock edge) and rd_data reads 0 for every index;
  - SYS_output_sel=2, no done pulse.
- start held high throughout a scan: exactly one frame per accept, no re-arm until IDLE. Also check rd_idx=5,6,7 returns 0.
- Parameter sweep NUM_SEL=1, SETTLE=1: frame length 2 cycles, done after E2, single bank entry correct.
